// File: rtl/queue_push_arbiter_if.sv
// rtl/queue_push_arbiter_if.sv - requester-side push bus shared by producers and the arbiter
interface queue_push_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0][WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;

  modport master (output req_valid, output req_data, input req_ready);
  modport slave  (input req_valid, input req_data, output req_ready);
endinterface

// File: rtl/queue_push_arbiter.sv
// rtl/queue_push_arbiter.sv - round-robin push arbiter in front of one queue, with occupancy tracking
module queue_push_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 32,
  parameter int NUM_BITS  = 3,
  parameter int AF_MARGIN = 2
) (
  input  logic                  clk0,
  input  logic                  rst0,
  queue_push_arbiter_if.slave   req,
  input  logic                  q_full,
  input  logic                  q_pop,
  input  logic                  q_empty,
  output logic                  q_push,
  output logic [WIDTH-1:0]      q_push_data,
  output logic [NUM_BITS:0]     occupancy,
  output logic                  almost_full,
  output logic                  err
);

  localparam int DEPTH = 2 ** NUM_BITS;
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int SUM_W = PTR_W + 1;
  localparam int CNT_W = NUM_BITS + 1;
  localparam logic [NUM_BITS:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [NUM_BITS:0] AF_LEVEL  = CNT_W'(DEPTH - AF_MARGIN);

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] grant_idx;
  logic             grant_any;
  logic [SUM_W-1:0] scan;
  logic             pop_acc;

  // Scan from rr_ptr with wrap; the first valid requester wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    scan      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = {1'b0, rr_ptr} + SUM_W'(k);
      if (scan >= SUM_W'(NUM_REQ)) begin
        scan = scan - SUM_W'(NUM_REQ);
      end
      if (!grant_any && req.req_valid[scan[PTR_W-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = scan[PTR_W-1:0];
      end
    end
    // A same-cycle pop cannot open a slot: the queue judges full before the edge.
    if (q_full || rst0) begin
      grant_any = 1'b0;
    end
  end

  assign req.req_ready = grant_any ? (NUM_REQ'(1) << grant_idx) : '0;
  assign q_push        = grant_any;
  assign q_push_data   = grant_any ? req.req_data[grant_idx] : '0;
  assign pop_acc       = q_pop && !q_empty;
  assign almost_full   = (occupancy >= AF_LEVEL);

  always_ff @(posedge clk0) begin
    if (rst0) begin
      rr_ptr    <= '0;
      occupancy <= '0;
      err       <= 1'b0;
    end else begin
      if (grant_any) begin
        rr_ptr <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
      end

      if (q_push && !pop_acc) begin
        if (occupancy != DEPTH_CNT) begin
          occupancy <= occupancy + CNT_W'(1);
        end
      end else if (pop_acc && !q_push) begin
        if (occupancy != '0) begin
          occupancy <= occupancy - CNT_W'(1);
        end
      end

      // Tracked count must agree with the queue's own full flag.
      if ((pop_acc && (occupancy == '0)) ||
          ((occupancy == DEPTH_CNT) && !q_full) ||
          ((occupancy != DEPTH_CNT) && q_full)) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_queue_push_arbiter.sv
// tb/tb_queue_push_arbiter.sv - directed scoreboard bench for queue_push_arbiter
module tb_queue_push_arbiter;
  logic        clk0 = 1'b0;
  logic        rst0 = 1'b1;
  logic        q_full = 1'b0;
  logic        q_pop = 1'b0;
  logic        q_empty = 1'b1;
  logic        q_push;
  logic [31:0] q_push_data;
  logic [3:0]  occupancy;
  logic        almost_full;
  logic        err;

  queue_push_arbiter_if #(.NUM_REQ(4), .WIDTH(32)) bus ();

  queue_push_arbiter #(.NUM_REQ(4), .WIDTH(32), .NUM_BITS(3), .AF_MARGIN(2)) dut (
    .clk0        (clk0),
    .rst0        (rst0),
    .req         (bus.slave),
    .q_full      (q_full),
    .q_pop       (q_pop),
    .q_empty     (q_empty),
    .q_push      (q_push),
    .q_push_data (q_push_data),
    .occupancy   (occupancy),
    .almost_full (almost_full),
    .err         (err)
  );

  always #5 clk0 = ~clk0;

  typedef struct {
    string       name;
    logic [3:0]  ready;
    logic        push;
    logic [31:0] data;
    logic [3:0]  occ;
    logic        af;
    logic        e;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic step(input string name, input logic rst, input logic [3:0] valid,
                      input logic full, input logic pop, input logic empty,
                      input logic [3:0] ready, input logic push, input logic [31:0] data,
                      input logic [3:0] occ, input logic af, input logic e);
    exp_t r;
    @(posedge clk0);
    #1;
    rst0          = rst;
    bus.req_valid = valid;
    q_full        = full;
    q_pop         = pop;
    q_empty       = empty;
    r.name  = name;
    r.ready = ready;
    r.push  = push;
    r.data  = data;
    r.occ   = occ;
    r.af    = af;
    r.e     = e;
    exp_q.push_back(r);
  endtask

  initial begin : monitor
    exp_t r;
    forever begin
      @(negedge clk0);
      if (exp_q.size() > 0) begin
        r = exp_q.pop_front();
        n_cmp++;
        if (bus.req_ready !== r.ready || q_push !== r.push || q_push_data !== r.data ||
            occupancy !== r.occ || almost_full !== r.af || err !== r.e) begin
          n_bad++;
          $display("FAIL %s: got ready=%b push=%b data=%h occ=%0d af=%b err=%b, want ready=%b push=%b data=%h occ=%0d af=%b err=%b",
                   r.name, bus.req_ready, q_push, q_push_data, occupancy, almost_full, err,
                   r.ready, r.push, r.data, r.occ, r.af, r.e);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : driver
    for (int i = 0; i < 4; i++) bus.req_data[i] = 32'hA0 + 32'(i);
    bus.req_valid = 4'hF;
    @(posedge clk0);

    step("reset0", 1, 4'hF, 0, 0, 1, 4'h0, 0, 32'h0, 4'd0, 0, 0);
    step("reset1", 1, 4'hF, 0, 0, 1, 4'h0, 0, 32'h0, 4'd0, 0, 0);

    step("rr0", 0, 4'hF, 0, 0, 1, 4'b0001, 1, 32'hA0, 4'd0, 0, 0);
    step("rr1", 0, 4'hF, 0, 0, 0, 4'b0010, 1, 32'hA1, 4'd1, 0, 0);
    step("rr2", 0, 4'hF, 0, 0, 0, 4'b0100, 1, 32'hA2, 4'd2, 0, 0);
    step("rr3", 0, 4'hF, 0, 0, 0, 4'b1000, 1, 32'hA3, 4'd3, 0, 0);
    step("rr4", 0, 4'hF, 0, 0, 0, 4'b0001, 1, 32'hA0, 4'd4, 0, 0);

    step("push_pop_at5", 0, 4'hF, 0, 1, 0, 4'b0010, 1, 32'hA1, 4'd5, 0, 0);
    step("idle_hold",    0, 4'h0, 0, 0, 0, 4'b0000, 0, 32'h0,  4'd5, 0, 0);
    step("sparse_wrap",  0, 4'b0011, 0, 0, 0, 4'b0001, 1, 32'hA0, 4'd5, 0, 0);
    step("sparse_next",  0, 4'b0011, 0, 0, 0, 4'b0010, 1, 32'hA1, 4'd6, 1, 0);

    for (int k = 0; k < 7; k++)
      step("drain", 0, 4'h0, 0, 1, 0, 4'h0, 0, 32'h0, 4'(7 - k), (7 - k) >= 6, 0);

    for (int k = 0; k < 8; k++)
      step("fill", 0, 4'b0010, 0, 0, k == 0, 4'b0010, 1, 32'hA1, 4'(k), k >= 6, 0);

    step("full_pop",   0, 4'b0010, 1, 1, 0, 4'h0, 0, 32'h0, 4'd8, 1, 0);
    step("after_full", 0, 4'h0,    0, 0, 0, 4'h0, 0, 32'h0, 4'd7, 1, 0);

    for (int k = 0; k < 4; k++)
      step("drain2", 0, 4'h0, 0, 1, 0, 4'h0, 0, 32'h0, 4'(7 - k), (7 - k) >= 6, 0);

    step("err_inject", 0, 4'h0, 1, 0, 0, 4'h0, 0, 32'h0, 4'd3, 0, 0);
    step("err_set",    0, 4'h0, 0, 0, 0, 4'h0, 0, 32'h0, 4'd3, 0, 1);
    step("err_hold",   0, 4'h0, 0, 0, 0, 4'h0, 0, 32'h0, 4'd3, 0, 1);
    step("err_rst",    1, 4'hF, 0, 0, 0, 4'h0, 0, 32'h0, 4'd3, 0, 1);
    step("post_rst",   0, 4'h0, 0, 0, 1, 4'h0, 0, 32'h0, 4'd0, 0, 0);
    step("post_rst_grant", 0, 4'b1000, 0, 0, 1, 4'b1000, 1, 32'hA3, 4'd0, 0, 0);

    @(posedge clk0);
    #1;
    bus.req_valid = 4'h0;
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk0);
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain_queue: got %0d pending, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/queue_push_arbiter.md
# queue_push_arbiter

Round-robin push arbiter that shares one `queue` instance between up to `NUM_REQ` producers (e.g. functional-unit writeback ports). Each cycle it selects at most one valid requester and drives the queue's push port. It tracks queue occupancy from the accepted pushes and pops, which yields an early `almost_full` indication and a sticky consistency-error flag. Arbitration and push are zero-latency (combinational). Priority pointer and occupancy state are registered.

## Interface
- `NUM_REQ`, default 4: number of requesters, ≥2.
- `WIDTH`, default 32: data width; matches the queue's `WIDTH`.
- `NUM_BITS`, default 3: queue depth is `DEPTH = 2**NUM_BITS`; matches the queue's `NUM_BITS`.
- `AF_MARGIN`, default 2: `almost_full` asserts when occupancy ≥ `DEPTH - AF_MARGIN`; must be in 1..DEPTH.
- `clk0`, in, 1: single clock; all state updates on its rising edge.
- `rst0`, in, 1: synchronous, active-high reset.
- `req_valid`, in, NUM_REQ: per-requester push request.
- `req_data`, in, NUM_REQ×WIDTH: per-requester push payload; `req_data[i]` belongs to requester i.
- `req_ready`, out, NUM_REQ: one-hot-or-zero grant; requester i's data is accepted this cycle iff `req_valid[i] && req_ready[i]`.
- `q_full`, in, 1: the queue's `full`.
- `q_pop`, in, 1: the consumer's pop to the queue.
- `q_empty`, in, 1: the queue's `empty`.
- `q_push`, out, 1: push to the queue.
- `q_push_data`, out, WIDTH: the granted requester's `req_data`.
- `occupancy`, out, NUM_BITS+1: tracked entry count, 0..DEPTH.
- `almost_full`, out, 1: `occupancy >= DEPTH - AF_MARGIN`.
- `err`, out, 1: sticky occupancy-mismatch flag.

## Operation
- State:
  - `rr_ptr` (index 0..NUM_REQ-1, reset 0).
  - `occupancy` (reset 0).
  - `err` (reset 0).
- Eligibility:
  - When `q_full` = 1 or `rst0` = 1, all `req_ready` = 0 and `q_push` = 0.
  - A same-cycle `q_pop` does not free a slot for a push, because the queue checks full against pre-edge state.
- Selection: grant the first i with `req_valid[i]` = 1, scanning `rr_ptr`, `rr_ptr+1`, … with wrap modulo NUM_REQ.
  - If no request is valid, no grant.
  - `q_push` = OR of grants; `q_push_data` = `req_data[granted]`.
  - When there is no grant, `q_push_data` = 0.
- Pointer update: on an accepted push from requester g, `rr_ptr <= (g+1) mod NUM_REQ`. Otherwise `rr_ptr` holds.
- Occupancy:
  - `push_acc = q_push`; `pop_acc = q_pop && !q_empty`.
  - Push only → +1. Pop only → −1. Both or neither → unchanged.
- Error detection: `err` sets, and then holds until reset, if any of the following occurs:
  - `pop_acc` while `occupancy` = 0;
  - `occupancy` = DEPTH while `q_full` = 0;
  - `occupancy` < DEPTH while `q_full` = 1.
- Error handling: on an illegal decrement, `occupancy` saturates at 0. It never exceeds DEPTH.
- Reset mid-operation: state returns to reset values on the next edge, and outputs are gated low in the reset cycle. Upstream producers must retry.

## Timing
- Request to grant: 0 cycles, combinational from `req_valid`, `rr_ptr`, `q_full` and `rst0`.
- Push to queue: the same cycle as the grant.
- `occupancy`, `almost_full` and `err` update on the edge after the accepted event (registered count; `almost_full` is combinational from the registered count).
- Reset values:
  - `req_ready` = 0, `q_push` = 0, `q_push_data` = 0.
  - `occupancy` = 0, `almost_full` = 0 (given AF_MARGIN < DEPTH), `err` = 0.
- Throughput: one push per cycle sustained while not full.
- Fairness: any continuously valid requester is granted within NUM_REQ accepted pushes.

## Test plan
- **Reset:** hold `rst0` = 1 for 2 cycles with all `req_valid` = 1111.
  - Expect `req_ready` = 0, `q_push` = 0, `occupancy` = 0, `err` = 0 throughout.
- **Round-robin rotation** (NUM_REQ=4, all requests valid, queue never full):
  - Expect grants in order 0, 1, 2, 3, 0.
  - `req_data[i]` = 0xA0+i, so `q_push_data` sequence is 0xA0, 0xA1, 0xA2, 0xA3, 0xA0.
- **Sparse requests:**
  - With `rr_ptr` = 2 and `req_valid` = 0011, expect the grant to go to requester 0, and `rr_ptr` to become 1 next cycle.
  - With `req_valid` = 0000, expect no grant and `rr_ptr` unchanged.
- **Fill to full** (DEPTH=8, AF_MARGIN=2), eight pushes from requester 1 with no pops:
  - `almost_full` rises after push 6; `occupancy` = 8.
  - Once `q_full` = 1, `req_ready` = 0 even with `q_pop` = 1 in that cycle.
- **Simultaneous push and pop** at `occupancy` = 5:
  - Expect `occupancy` to stay 5 and `rr_ptr` to advance.
- **Error injection:** drive `q_full` = 1 while `occupancy` = 3.
  - Expect `err` = 1 the next cycle, still 1 after the condition clears, and cleared only by `rst0`.
